uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares one UART transmitter among NUM_REQ requesters. Each requester offers a byte with a valid/ready handshake. The arbiter grants one requester, launches the transmitter with a one-cycle start pulse, and waits for frame completion before granting again. A watchdog recovers the arbiter if the transmitter never reports done. It sits between protocol/command logic and the single uart_tx instance, on the same clock as the UART datapath.

---
 rtl/uart_tx_arbiter.sv | 101 ++++++++++
 tb/tb_uart_tx_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ valid/ready requesters.
// One grant per frame; a watchdog returns to idle if the transmitter never reports done.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned TIMEOUT_CYCLES = 5000,
  localparam int unsigned IdW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        tx_start,
  output logic [DATA_W-1:0]           tx_data,
  input  logic                        tx_busy,
  input  logic                        tx_done,
  output logic [IdW-1:0]              grant_id,
  output logic                        busy,
  output logic                        err_timeout
);

  typedef enum logic [0:0] {StIdle, StWaitDone} state_e;

  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

  state_e         state_q;
  logic [IdW-1:0] rr_ptr_q;
  logic [15:0]    cnt_q;

  logic           pick_found;
  logic [IdW-1:0] pick_idx;
  logic [IdW-1:0] pick_next;
  logic [IdW-1:0] scan_idx;
  int unsigned    scan;

  // First valid requester scanning upward from rr_ptr_q, wrapping at NUM_REQ.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan       = 0;
    scan_idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan = int'(rr_ptr_q) + k;
      if (scan >= NUM_REQ) scan = scan - NUM_REQ;
      scan_idx = IdW'(scan);
      if (!pick_found && req_valid[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx;
      end
    end
    pick_next = (pick_idx == IdW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      cnt_q       <= '0;
      req_ready   <= '0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      grant_id    <= '0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      req_ready   <= '0;
      tx_start    <= 1'b0;
      err_timeout <= 1'b0;
      case (state_q)
        StIdle: begin
          if (!tx_busy && pick_found) begin
            req_ready <= NUM_REQ'(1) << pick_idx;
            tx_start  <= 1'b1;
            tx_data   <= req_data[pick_idx*DATA_W +: DATA_W];
            grant_id  <= pick_idx;
            busy      <= 1'b1;
            rr_ptr_q  <= pick_next;
            cnt_q     <= '0;
            state_q   <= StWaitDone;
          end
        end
        StWaitDone: begin
          // tx_done takes priority over a watchdog expiry in the same cycle.
          if (tx_done) begin
            busy    <= 1'b0;
            state_q <= StIdle;
          end else if (TIMEOUT_CYCLES != 0 && cnt_q == TimeoutLast) begin
            busy        <= 1'b0;
            err_timeout <= 1'b1;
            state_q     <= StIdle;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios, a per-cycle reference model compared on every
// negedge, and literal expectations at key points of each scenario.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TO = 20;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           tx_start;
  logic [W-1:0]   tx_data;
  logic           tx_busy;
  logic           tx_done;
  logic [1:0]     grant_id;
  logic           busy;
  logic           err_timeout;

  uart_tx_arbiter #(
    .NUM_REQ       (N),
    .DATA_W        (W),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .grant_id   (grant_id),
    .busy       (busy),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int rdy_pulses = 0;
  int err_pulses = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: expected registered outputs, updated from the inputs seen at each edge.
  logic [N-1:0] e_ready = '0;
  logic         e_start = 1'b0;
  logic [W-1:0] e_data  = '0;
  logic [1:0]   e_gid   = '0;
  logic         e_busy  = 1'b0;
  logic         e_err   = 1'b0;
  int           m_ptr   = 0;
  int           m_cnt   = 0;
  bit           m_wait  = 1'b0;
  int           w_m;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      e_ready <= '0; e_start <= 1'b0; e_data <= '0; e_gid <= '0;
      e_busy  <= 1'b0; e_err <= 1'b0; m_ptr <= 0; m_cnt <= 0; m_wait <= 1'b0;
    end else begin
      e_ready <= '0;
      e_start <= 1'b0;
      e_err   <= 1'b0;
      if (!m_wait) begin
        if (!tx_busy && req_valid != '0) begin
          w_m = -1;
          for (int k = 0; k < N; k++)
            if (w_m < 0 && ((req_valid >> ((m_ptr + k) % N)) & 4'b0001) != 0) w_m = (m_ptr + k) % N;
          e_ready <= 4'b0001 << w_m;
          e_start <= 1'b1;
          e_data  <= W'(req_data >> (w_m * W));
          e_gid   <= 2'(w_m);
          e_busy  <= 1'b1;
          m_ptr   <= (w_m + 1) % N;
          m_wait  <= 1'b1;
          m_cnt   <= 1;
        end
      end else if (tx_done) begin
        m_wait <= 1'b0;
        e_busy <= 1'b0;
      end else if (m_cnt == TO) begin
        m_wait <= 1'b0;
        e_busy <= 1'b0;
        e_err  <= 1'b1;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  always @(negedge clk) begin
    check("cmp_req_ready", req_ready, e_ready);
    check("cmp_tx_start", tx_start, e_start);
    check("cmp_tx_data", tx_data, e_data);
    check("cmp_grant_id", grant_id, e_gid);
    check("cmp_busy", busy, e_busy);
    check("cmp_err_timeout", err_timeout, e_err);
    if (req_ready != '0) rdy_pulses++;
    if (err_timeout) err_pulses++;
  end

  task automatic wait_start(input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (tx_start) ok = 1'b1;
    end
    if (!ok) check(name, 0, 1);
  endtask

  task automatic done_pulse();
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
  endtask

  bit ok;
  int k_err, e0, r0;
  int gids[5];
  int starts[5];
  int exp_order[5] = '{0, 1, 2, 3, 0};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b1; req_valid = 4'b1111; req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    tx_busy = 1'b0; tx_done = 1'b0;

    // Reset held with every requester valid.
    repeat (2) begin
      @(negedge clk);
      check("t1_rst_busy", busy, 0);
      check("t1_rst_start", tx_start, 0);
      check("t1_rst_ready", req_ready, 0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("t1_start", tx_start, 1);
    check("t1_gid", grant_id, 0);
    check("t1_ready", req_ready, 4'b0001);
    check("t1_data", tx_data, 8'h11);
    req_valid = '0;
    done_pulse();
    check("t1_idle", busy, 0);

    // Single request from requester 2.
    req_data[23:16] = 8'hA5;
    req_valid = 4'b0100;
    @(negedge clk);
    check("t2_ready", req_ready, 4'b0100);
    check("t2_start", tx_start, 1);
    check("t2_data", tx_data, 8'hA5);
    check("t2_gid", grant_id, 2);
    req_valid = '0;
    @(negedge clk);
    check("t2_start_once", tx_start, 0);
    repeat (2) @(negedge clk);
    check("t2_busy_held", busy, 1);
    done_pulse();
    check("t2_busy_drop", busy, 0);
    check("t2_data_kept", tx_data, 8'hA5);

    // Grant held off while the transmitter is busy.
    tx_busy = 1'b1;
    req_valid = 4'b0001;
    repeat (4) begin
      @(negedge clk);
      check("t4_gated", tx_start, 0);
    end
    check("t4_gated_busy", busy, 0);
    tx_busy = 1'b0;
    @(negedge clk);
    check("t4_start", tx_start, 1);
    check("t4_gid", grant_id, 0);
    req_valid = '0;
    done_pulse();

    // Watchdog abort, then re-grant to the other pending requester.
    e0 = err_pulses;
    req_data[15:8] = 8'h5A;
    req_valid = 4'b1010;
    wait_start("t5_first_start", ok);
    check("t5_gid1", grant_id, 1);
    req_valid = 4'b1000;
    k_err = 0;
    for (int i = 1; i <= 30 && k_err == 0; i++) begin
      @(negedge clk);
      if (err_timeout) begin
        k_err = i;
        check("t5_busy_at_err", busy, 0);
      end
    end
    check("t5_err_delay", k_err, 20);
    @(negedge clk);
    check("t5_regrant_start", tx_start, 1);
    check("t5_regrant_gid", grant_id, 3);
    check("t5_err_once", err_pulses - e0, 1);
    req_valid = '0;
    // tx_done in the same cycle the watchdog would expire.
    e0 = err_pulses;
    repeat (19) @(negedge clk);
    done_pulse();
    repeat (3) @(negedge clk);
    check("t5_done_wins", err_pulses - e0, 0);
    check("t5_done_idle", busy, 0);

    // Round robin with every requester held valid, frames of 10 cycles.
    req_valid = 4'b1111;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    r0 = rdy_pulses;
    for (int f = 0; f < 5; f++) begin
      wait_start("t3_start", ok);
      gids[f] = int'(grant_id);
      starts[f] = cyc;
      if (f == 4) req_valid = '0;
      repeat (10) @(negedge clk);
      done_pulse();
    end
    for (int f = 0; f < 5; f++) begin
      check("t3_order", gids[f], exp_order[f]);
      if (f > 0) check("t3_spacing", starts[f] - starts[f-1], 12);
    end
    check("t3_ready_pulses", rdy_pulses - r0, 5);

    // Reset in the middle of a frame.
    req_valid = 4'b1000;
    wait_start("t6_start", ok);
    check("t6_gid3", grant_id, 3);
    req_valid = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_rst_busy", busy, 0);
    done_pulse();
    check("t6_late_done_busy", busy, 0);
    check("t6_late_done_start", tx_start, 0);
    req_valid = 4'b1001;
    @(negedge clk);
    check("t6_start", tx_start, 1);
    check("t6_gid0", grant_id, 0);
    req_valid = '0;
    done_pulse();
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
